// File: rtl/rca_share_seq_if.sv
// Request/response bundle for rca_share_seq; sub_in exists only when
// RCA_SHARE_SUB_EN is defined.
interface rca_share_seq_if #(
    parameter int WORDS = 4
);
    localparam int W = 16 * WORDS;

    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [W-1:0] a0, b0, a1, b1;
    logic [1:0]   cin_in;
`ifdef RCA_SHARE_SUB_EN
    logic [1:0]   sub_in;
`endif
    logic         busy;
    logic         done;
    logic         done_id;
    logic [W-1:0] sum;
    logic         cout;

    modport master (
`ifdef RCA_SHARE_SUB_EN
        output sub_in,
`endif
        output req_valid, a0, b0, a1, b1, cin_in,
        input  req_ready, busy, done, done_id, sum, cout
    );

    modport slave (
`ifdef RCA_SHARE_SUB_EN
        input  sub_in,
`endif
        input  req_valid, a0, b0, a1, b1, cin_in,
        output req_ready, busy, done, done_id, sum, cout
    );
endinterface

// File: rtl/rca_share_seq.sv
// Two-requester multi-precision adder streaming 16-bit slices through one shared
// ripple-carry adder. Define RCA_SHARE_SUB_EN to add per-requester subtract.
module sixteen_bit_adder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout
);
    logic [16:0] c;

    assign c[0] = cin;
    for (genvar i = 0; i < 16; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign cout = c[16];
endmodule

module rca_share_seq #(
    parameter int WORDS = 4
) (
    input logic          clk,
    input logic          rst,
    rca_share_seq_if.slave bus
);
    localparam int W  = 16 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic         carry_q, carry_d;
    logic         last_q, last_d;
    logic         owner_q, owner_d;
    logic         sub_q, sub_d;
    logic [W-1:0] a_q, a_d, b_q, b_d, work_q, work_d, sum_q, sum_d;
    logic         cout_q, cout_d, done_q, done_d, done_id_q, done_id_d;
    logic         busy_q, busy_d;

    logic [1:0]   ready;
    logic         gid;
    logic         gsub;
    logic [15:0]  a_sl, b_sl, add_s;
    logic         add_co;

    sixteen_bit_adder u_add (
        .a    (a_sl),
        .b    (b_sl),
        .cin  (carry_q),
        .s    (add_s),
        .cout (add_co)
    );

`ifdef RCA_SHARE_SUB_EN
    assign gsub = bus.sub_in[gid];
`else
    assign gsub = 1'b0;
`endif

    // Round robin on a tie: last_q resets to 1 so requester 0 wins first.
    always_comb begin
        ready = 2'b00;
        if (state_q == IDLE && !rst) begin
            case (bus.req_valid)
                2'b01:   ready = 2'b01;
                2'b10:   ready = 2'b10;
                2'b11:   ready = last_q ? 2'b01 : 2'b10;
                default: ready = 2'b00;
            endcase
        end
        gid = ready[1];
    end

    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (idx_q == IW'(k)) begin
                a_sl = a_q[16*k +: 16];
                b_sl = b_q[16*k +: 16] ^ {16{sub_q}};
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        last_d    = last_q;
        owner_d   = owner_q;
        sub_d     = sub_q;
        a_d       = a_q;
        b_d       = b_q;
        work_d    = work_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        busy_d    = busy_q;
        case (state_q)
            IDLE: if (|ready) begin
                a_d     = gid ? bus.a1 : bus.a0;
                b_d     = gid ? bus.b1 : bus.b0;
                sub_d   = gsub;
                carry_d = gsub | bus.cin_in[gid];
                idx_d   = '0;
                last_d  = gid;
                owner_d = gid;
                busy_d  = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                for (int k = 0; k < WORDS; k++)
                    if (idx_q == IW'(k)) work_d[16*k +: 16] = add_s;
                carry_d = add_co;
                idx_d   = idx_q + IW'(1);
                // Result registers load here so they are valid during the done cycle.
                if (idx_q == IW'(WORDS - 1)) begin
                    idx_d     = '0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    sum_d     = work_d;
                    cout_d    = add_co;
                    done_id_d = owner_q;
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            sub_q     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            work_q    <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            carry_q   <= carry_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            sub_q     <= sub_d;
            a_q       <= a_d;
            b_q       <= b_d;
            work_q    <= work_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.req_ready = ready;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.done_id   = done_id_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
endmodule

// File: tb/tb_rca_share_seq.sv
// Directed bench for rca_share_seq with WORDS=4: vector table plus arbitration,
// reset-abort and optional subtract sequences.
module tb_rca_share_seq;
    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    rca_share_seq_if #(.WORDS(WORDS)) bus ();

    rca_share_seq #(.WORDS(WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   vld;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         co;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Call at a negedge with the request already driven. Returns in the done cycle.
    task automatic accept_and_check(input logic [1:0] exp_rdy, input logic [1:0] hold,
                                    input logic [W-1:0] exp_sum, input logic exp_co,
                                    input logic exp_id, input string tag);
        int lat;
        #1;
        chk({tag, " ready"}, W'(bus.req_ready), W'(exp_rdy));
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = hold;
        if (exp_id) begin bus.a1 = ~bus.a1; bus.b1 = ~bus.b1; end
        else        begin bus.a0 = ~bus.a0; bus.b0 = ~bus.b0; end
        #1;
        chk({tag, " busy_run"}, W'(bus.busy), W'(1));
        chk({tag, " ready_run"}, W'(bus.req_ready), W'(0));
        lat = 1;
        while (bus.done !== 1'b1 && lat < 12) begin
            @(negedge clk);
            #1;
            lat++;
        end
        chk({tag, " latency"}, W'(lat), W'(WORDS + 1));
        chk({tag, " sum"}, bus.sum, exp_sum);
        chk({tag, " cout"}, W'(bus.cout), W'(exp_co));
        chk({tag, " done_id"}, W'(bus.done_id), W'(exp_id));
        chk({tag, " busy_done"}, W'(bus.busy), W'(0));
        chk({tag, " ready_done"}, W'(bus.req_ready), W'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        vecs[0] = '{2'b01, 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0};
        vecs[1] = '{2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1};
        vecs[2] = '{2'b01, 64'h1, 64'h4, 1'b1, 64'h6, 1'b0};
        vecs[3] = '{2'b10, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1};
        vecs[4] = '{2'b01, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
                    64'h2222_2222_2222_2211, 1'b0};

        bus.req_valid = 2'b11;
        bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
        bus.cin_in = 2'b00;
`ifdef RCA_SHARE_SUB_EN
        bus.sub_in = 2'b00;
`endif
        repeat (2) @(negedge clk);
        #1;
        chk("rst busy", W'(bus.busy), W'(0));
        chk("rst done", W'(bus.done), W'(0));
        chk("rst done_id", W'(bus.done_id), W'(0));
        chk("rst sum", bus.sum, W'(0));
        chk("rst cout", W'(bus.cout), W'(0));
        chk("rst ready", W'(bus.req_ready), W'(0));
        @(negedge clk);
        bus.req_valid = 2'b00;
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.req_valid = vecs[i].vld;
            if (vecs[i].vld[0]) begin bus.a0 = vecs[i].a; bus.b0 = vecs[i].b; end
            else                begin bus.a1 = vecs[i].a; bus.b1 = vecs[i].b; end
            bus.cin_in = {vecs[i].cin, vecs[i].cin};
            accept_and_check(vecs[i].vld, 2'b00, vecs[i].s, vecs[i].co, vecs[i].vld[1],
                             $sformatf("vec%0d", i));
            @(negedge clk);
            #1;
            chk($sformatf("vec%0d done_pulse", i), W'(bus.done), W'(0));
        end

        // Tie from reset: 0 first, 1 next, then 0 again while both keep asking.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.cin_in = 2'b00;
        bus.a0 = 64'd16;  bus.b0 = 64'd64;
        bus.a1 = 64'd208; bus.b1 = 64'd32;
        bus.req_valid = 2'b11;
        accept_and_check(2'b01, 2'b11, 64'd80, 1'b0, 1'b0, "tie0");
        @(negedge clk);
        accept_and_check(2'b10, 2'b01, 64'd240, 1'b0, 1'b1, "tie1");
        @(negedge clk);
        accept_and_check(2'b01, 2'b00, 64'hFFFF_FFFF_FFFF_FFAE, 1'b1, 1'b0, "tie2");

        // Reset two cycles after acceptance aborts and restores last_grant.
        @(negedge clk);
        bus.a0 = 64'd24575; bus.b0 = 64'd27967;
        bus.req_valid = 2'b01;
        #1;
        chk("abort ready", W'(bus.req_ready), W'(1));
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort busy", W'(bus.busy), W'(0));
        chk("abort done", W'(bus.done), W'(0));
        chk("abort sum", bus.sum, W'(0));
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (bus.done === 1'b1) seen = 1'b1;
        end
        chk("abort no_done", W'(seen), W'(0));
        @(negedge clk);
        bus.a1 = 64'd1; bus.b1 = 64'd2;
        bus.req_valid = 2'b11;
        accept_and_check(2'b01, 2'b00, 64'd52542, 1'b0, 1'b0, "post_abort");

`ifdef RCA_SHARE_SUB_EN
        @(negedge clk);
        bus.a0 = 64'd5; bus.b0 = 64'd7; bus.cin_in = 2'b00; bus.sub_in = 2'b01;
        bus.req_valid = 2'b01;
        accept_and_check(2'b01, 2'b00, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, "sub_neg");
        @(negedge clk);
        bus.a0 = 64'd7; bus.b0 = 64'd5; bus.sub_in = 2'b01;
        bus.req_valid = 2'b01;
        accept_and_check(2'b01, 2'b00, 64'd2, 1'b1, 1'b0, "sub_pos");
`endif

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
